// File: rtl/shift_seq.sv
// Multi-cycle shifter: one single-bit step per clock, with sticky sign-change overflow.
// A new request is accepted in IDLE or DONE; requests arriving while busy are dropped.
module shift_seq #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] a,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             of
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASL = 2'b10;
    localparam logic [1:0] MODE_ASR = 2'b11;

    state_t                  state, state_nxt;
    logic signed [WIDTH-1:0] acc, acc_nxt, step_v;
    logic        [AMT_W-1:0] cnt, cnt_nxt;
    logic        [1:0]       mode_r, mode_nxt;
    logic                    of_r, of_nxt;

    // Single-bit step; left shifts are identical for logical and arithmetic modes.
    function automatic logic signed [WIDTH-1:0] shift_step(
        input logic signed [WIDTH-1:0] cur,
        input logic        [1:0]       m
    );
        case (m)
            MODE_LSR: shift_step = {1'b0, cur[WIDTH-1:1]};
            MODE_ASR: shift_step = cur >>> 1;
            MODE_LSL,
            MODE_ASL: shift_step = {cur[WIDTH-2:0], 1'b0};
            default:  shift_step = cur;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            mode_r <= MODE_LSL;
            of_r   <= 1'b0;
        end else begin
            state  <= state_nxt;
            acc    <= acc_nxt;
            cnt    <= cnt_nxt;
            mode_r <= mode_nxt;
            of_r   <= of_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        mode_nxt  = mode_r;
        of_nxt    = of_r;
        step_v    = shift_step(acc, mode_r);
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    acc_nxt   = $signed(a);
                    cnt_nxt   = amt;
                    mode_nxt  = mode;
                    of_nxt    = 1'b0;
                    state_nxt = (amt == '0) ? DONE : SHIFT;
                end else if (state == DONE) begin
                    state_nxt = IDLE;
                end
            end
            SHIFT: begin
                acc_nxt = step_v;
                of_nxt  = of_r | (acc[WIDTH-1] ^ step_v[WIDTH-1]);
                cnt_nxt = cnt - AMT_W'(1);
                if (cnt == AMT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);
    assign y    = acc;
    assign of   = of_r;

endmodule

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width in bits.
REQ-002 Parameter: AMT_W, 4, shift-amount width in bits (max amount 2^AMT_W-1 = 15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request pulse; sampled only when busy=0.
REQ-006 mode  input  2  00 LSL, 01 LSR, 10 ASL, 11 ASR; sampled with start.
REQ-007 amt  input  AMT_W  number of single-bit steps; sampled with start.
REQ-008 a  input  WIDTH  operand; sampled with start.
REQ-009 busy  output  1  high while an operation is in progress (state SHIFT).
REQ-010 done  output  1  one-cycle pulse: y/of valid.
REQ-011 y  output  WIDTH  result; held from done until next accepted start.
REQ-012 of  output  1  sticky overflow for the operation; held with y.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-014 One step per cycle, each step SHALL be: LSL next={cur[14:0],0}; LSR next={0,cur[15:1]}; ASL identical to LSL; ASR next={cur[15],cur[15:1]}.
REQ-015 Per-step overflow SHALL be cur[15] XOR next[15]; of SHALL be the OR of all per-step overflows of the operation (ASR therefore always 0).
REQ-016 Start acceptance: start=1 in IDLE or DONE SHALL load acc=a, cnt=amt, mode register, clear of; start while busy=1 SHALL be ignored with no effect.
REQ-017 On acceptance with amt=0, next state SHALL be DONE (y=a, of=0); with amt>0, next state SHALL be SHIFT.
REQ-018 In SHIFT each edge SHALL apply one step to acc, OR step overflow into of, decrement cnt; when cnt=1 before the edge, next state SHALL be DONE.
REQ-019 Latency: done SHALL be high exactly amt+1 rising edges after the edge that samples start (amt=0 -> 1 edge, amt=15 -> 16 edges).
REQ-020 done SHALL be high only in DONE, for exactly one cycle; DONE SHALL go to IDLE next edge unless start=1, which starts a new operation (back-to-back, no bubble).
REQ-021 busy SHALL equal (state==SHIFT); busy=0 in IDLE and DONE.
REQ-022 y SHALL be driven from acc; y SHALL change only during SHIFT or on acceptance; y SHALL be stable from done until the next accepted start.
REQ-023 Inputs mode/amt/a changing while busy SHALL NOT affect the running operation.
REQ-024 amt wider than WIDTH-1 is impossible by width; amt=15 LSL/LSR SHALL leave only one original bit.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force state=IDLE, acc=0, cnt=0, of=0, mode register=00; outputs busy=0, done=0, y=0x0000, of=0.
REQ-026 Reset asserted mid-operation SHALL abort it with no done pulse; start in the same cycle as rst_n=0 SHALL be ignored.
REQ-027 First start SHALL be accepted on the first edge with rst_n=1.

Verification
REQ-028 LSL a=0x4001 amt=1 -> done 2 edges after start, y=0x8002, of=1.
REQ-029 LSR a=0x8000 amt=15 -> busy 15 cycles, done at edge 16, y=0x0001, of=1.
REQ-030 ASR a=0x8000 amt=4 -> y=0xF800, of=0; ASL a=0x0003 amt=0 -> done at edge 1, y=0x0003, of=0.
REQ-031 Start LSL a=0x0001 amt=3, pulse start with a=0xFFFF at edge 2 -> ignored, y=0x0008, of=0; new start on done cycle (ASR a=0xFF00 amt=8) -> no idle bubble, y=0xFFFF, of=0.
REQ-032 Start LSR a=0xFFFF amt=10, drive rst_n=0 at edge 4 -> next cycle busy=0, done=0, y=0x0000, of=0; no done pulse afterwards.
